hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard controller for the five-stage core. It drives the stall and flush controls of every pipeline register, including `en`/`clr` of the fetch/decode register, and the ALU operand forwarding selects. It resolves load-use, taken branch/jump, and multi-cycle data-memory wait hazards. A watchdog latches a fault if the memory wait never ends.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 5, register-file index width
- `TIMEOUT`, 64, consecutive `MemBusyM` cycles before fault (≥2)
- `CNT_WIDTH`, 32, width of the performance counters

Ports:
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `Rs1D`, `Rs2D` in `REG_ADDR_WIDTH`: source registers in Decode
- `Rs1E`, `Rs2E`, `RdE` in `REG_ADDR_WIDTH`: Execute sources and destination
- `RdM`, `RdW` in `REG_ADDR_WIDTH`: Memory and Writeback destinations
- `MemReadE` in 1: Execute instruction is a load
- `RegWriteM`, `RegWriteW` in 1: destination writes are valid
- `PCSrcE` in 1: taken branch or jump resolved in Execute
- `MemBusyM` in 1: data memory not ready this cycle
- `StallF`, `StallD`, `StallE`, `StallM` out 1: hold the PC and pipeline registers (`StallD` → fetch/decode `en`)
- `FlushD`, `FlushE`, `FlushW` out 1: clear the pipeline registers (`FlushD` → fetch/decode `clr`)
- `ForwardAE`, `ForwardBE` out 2: operand select, 00 = register file, 01 = from W, 10 = from M
- `Fault` out 1: watchdog tripped (sticky)

## Operation
- States: `RUN`, `MEM_WAIT`, `FAULT`.
- Outputs are combinational from the state and inputs. The state and wait counter are registered.
- Forwarding is evaluated in every state. For operand A:
  - 10 if `RegWriteM` && `RdM`≠0 && `RdM`==`Rs1E`;
  - else 01 if `RegWriteW` && `RdW`≠0 && `RdW`==`Rs1E`;
  - else 00.
  - Operand B is the same with `Rs2E`. M has priority over W.
- Load-use condition `lu` = `MemReadE` && `RdE`≠0 && (`RdE`==`Rs1D` || `RdE`==`Rs2D`).
- `RUN` with `MemBusyM`=0:
  - `PCSrcE`=1: `FlushD`=`FlushE`=1; all stalls 0. The branch wins over `lu`, because the instruction in Decode is wrong-path.
  - else if `lu`: `StallF`=`StallD`=1, `FlushE`=1.
  - else all controls 0.
- `RUN` or `MEM_WAIT` with `MemBusyM`=1:
  - `StallF`/`D`/`E`/`M`=1, `FlushW`=1, `FlushD`=`FlushE`=0.
  - This overrides both the branch and `lu` cases. `PCSrcE` stays held in Execute, so its flush takes effect on the first non-busy cycle.
- `MEM_WAIT` with `MemBusyM`=0: same decode as `RUN`, and the next state is `RUN`.
- `FAULT`:
  - all four stalls = 1, all flushes = 0, `Fault`=1;
  - the block leaves this state only on reset.
- Invariant: `StallD` and `FlushD` are never both 1, because the fetch/decode register gives `clr` priority over `en`.

## Timing
- Reset (`rst_n`=0, asynchronous): state `RUN`, wait counter 0, `Fault`=0, performance counters 0. With all inputs 0, every output is 0.
- Reset released in mid-wait: the block returns to `RUN`, and the counter restarts from 0.
- Wait counter:
  - set to 1 on the edge where `RUN` samples `MemBusyM`=1, with the transition to `MEM_WAIT`;
  - incremented on each `MEM_WAIT` edge that samples `MemBusyM`=1;
  - cleared when the block returns to `RUN`.
- Fault: the edge that samples the `TIMEOUT`-th consecutive busy cycle moves the block to `FAULT`. `Fault` is visible the following cycle.
- If `MemBusyM` drops in the same cycle the count would reach `TIMEOUT`, no fault occurs.
- Stall and flush responses take zero cycles, in the same cycle as the hazard.
- A load-use stall lasts exactly 1 cycle, because the load moves to M, which clears `lu`.

## Configuration
- `HAZARD_PERF_EN` defined: adds two output ports, `StallCount` and `FlushCount`, each `CNT_WIDTH` bits.
  - `StallCount` counts cycles with `StallD`=1.
  - `FlushCount` counts cycles with `FlushD`=1.
  - Both wrap on overflow and are cleared by reset.
- `HAZARD_PERF_EN` undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Package `hazard_pkg` holds:
  - the state enum (`RUN`, `MEM_WAIT`, `FAULT`);
  - the forward-select constants `FWD_REG`=2'b00, `FWD_W`=2'b01, `FWD_M`=2'b10.
- Sub-module `forward_unit`: combinational, one source index in and a 2-bit select out. It is instantiated twice, once for A and once for B.

## Test plan
- `Rs1E`=5, `RdM`=5, `RegWriteM`=1, `RdW`=5, `RegWriteW`=1 → `ForwardAE`=10. With `RdM`=0 → `ForwardAE`=01. With `RdW`=0 as well → 00.
- `MemReadE`=1, `RdE`=3, `Rs2D`=3 → for one cycle `StallF`=`StallD`=`FlushE`=1 and `FlushD`=0. Next cycle (load in M) → all controls 0.
- `PCSrcE`=1 together with the load-use condition → `FlushD`=`FlushE`=1 and `StallD`=0.
- `MemBusyM`=1 for 3 cycles while `PCSrcE`=1 → 3 cycles of all stalls plus `FlushW`, with no D/E flush. Then `FlushD`=`FlushE`=1 on the 4th cycle.
- `TIMEOUT`=4, `MemBusyM` held high → `Fault`=1 from cycle 5 with all stalls 1. Pulling `rst_n` low → `Fault`=0 asynchronously.
- `HAZARD_PERF_EN` defined, 2 load-use stalls and 1 branch → `StallCount`=2, `FlushCount`=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
//   hz_state_e : controller FSM states (RUN, MEM_WAIT, FAULT)
//   FWD_*      : ALU operand forward-select encodings
//   hz_ctl_t   : bundle of pipeline stall/flush controls
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FAULT    = 2'b10
    } hz_state_e;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic stall_e;
        logic stall_m;
        logic flush_d;
        logic flush_e;
        logic flush_w;
    } hz_ctl_t;

endpackage

// File: rtl/forward_unit.sv
// forward_unit: ALU operand forward-select for one Execute source register.
// Ports:
//   rs_i            : source register index in Execute
//   rd_m_i, rd_w_i  : destination indices in Memory / Writeback
//   reg_write_m_i/w : destination write valid in Memory / Writeback
//   fwd_sel_o       : FWD_M (M wins over W), FWD_W, or FWD_REG
module forward_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic [REG_ADDR_WIDTH-1:0] rs_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_m_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_w_i,
    input  logic                      reg_write_m_i,
    input  logic                      reg_write_w_i,
    output logic [1:0]                fwd_sel_o
);

    always_comb begin
        fwd_sel_o = FWD_REG;
        // x0 is hard-wired zero, so a write to it is never forwarded.
        if (reg_write_m_i && (rd_m_i != '0) && (rd_m_i == rs_i)) begin
            fwd_sel_o = FWD_M;
        end else if (reg_write_w_i && (rd_w_i != '0) && (rd_w_i == rs_i)) begin
            fwd_sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage core.
// Resolves load-use, taken branch/jump and data-memory wait hazards, drives
// the operand forwarding selects, and latches a sticky fault when the memory
// wait lasts TIMEOUT consecutive cycles.
// Ports:
//   clk, rst_n                 : clock (rising edge), async active-low reset
//   Rs1D, Rs2D                 : Decode source registers
//   Rs1E, Rs2E, RdE            : Execute sources / destination
//   RdM, RdW                   : Memory / Writeback destinations
//   MemReadE                   : Execute instruction is a load
//   RegWriteM, RegWriteW       : destination write valid in M / W
//   PCSrcE                     : taken branch or jump resolved in Execute
//   MemBusyM                   : data memory not ready this cycle
//   StallF/D/E/M               : hold PC and pipeline registers
//   FlushD/E/W                 : clear pipeline registers
//   ForwardAE, ForwardBE       : operand selects (00 RF, 01 W, 10 M)
//   Fault                      : watchdog tripped (sticky until reset)
//   StallCount, FlushCount     : performance counters, only when the macro
//                                HAZARD_PERF_EN is defined
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT        = 64,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,
    input  logic [REG_ADDR_WIDTH-1:0] RdM,
    input  logic [REG_ADDR_WIDTH-1:0] RdW,
    input  logic                      MemReadE,
    input  logic                      RegWriteM,
    input  logic                      RegWriteW,
    input  logic                      PCSrcE,
    input  logic                      MemBusyM,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushW,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
`ifdef HAZARD_PERF_EN
    output logic                      Fault,
    output logic [CNT_WIDTH-1:0]      StallCount,
    output logic [CNT_WIDTH-1:0]      FlushCount
`else
    output logic                      Fault
`endif
);

    localparam int unsigned WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);
    localparam logic [WCW-1:0] WAIT_ONE  = WCW'(1);

    if (TIMEOUT < 2 || CNT_WIDTH < 1) begin : g_param_check
        $error("hazard_ctrl: TIMEOUT must be >= 2 and CNT_WIDTH >= 1");
    end

    hz_state_e      state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    hz_ctl_t        ctl;
    logic           lu;

    // ---------------- forwarding (independent of state) ----------------
    forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs_i          (Rs1E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_sel_o     (ForwardAE)
    );

    forward_unit #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs_i          (Rs2E),
        .rd_m_i        (RdM),
        .rd_w_i        (RdW),
        .reg_write_m_i (RegWriteM),
        .reg_write_w_i (RegWriteW),
        .fwd_sel_o     (ForwardBE)
    );

    assign lu = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // ---------------- FSM: next state and controls ----------------
    always_comb begin
        ctl        = '0;
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;

        unique case (state_q)
            RUN, MEM_WAIT: begin
                if (MemBusyM) begin
                    // Freeze everything up to M; the branch stays held in
                    // Execute and flushes on the first non-busy cycle.
                    ctl.stall_f = 1'b1;
                    ctl.stall_d = 1'b1;
                    ctl.stall_e = 1'b1;
                    ctl.stall_m = 1'b1;
                    ctl.flush_w = 1'b1;
                    if (state_q == RUN) begin
                        state_d    = MEM_WAIT;
                        wait_cnt_d = WAIT_ONE;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        // This edge samples the TIMEOUT-th busy cycle.
                        state_d    = FAULT;
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_ONE;
                    end
                end else begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    if (PCSrcE) begin
                        // Decode holds a wrong-path instruction, so the
                        // branch flush takes precedence over a load-use stall.
                        ctl.flush_d = 1'b1;
                        ctl.flush_e = 1'b1;
                    end else if (lu) begin
                        ctl.stall_f = 1'b1;
                        ctl.stall_d = 1'b1;
                        ctl.flush_e = 1'b1;
                    end
                end
            end
            FAULT: begin
                ctl.stall_f = 1'b1;
                ctl.stall_d = 1'b1;
                ctl.stall_e = 1'b1;
                ctl.stall_m = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    assign StallF = ctl.stall_f;
    assign StallD = ctl.stall_d;
    assign StallE = ctl.stall_e;
    assign StallM = ctl.stall_m;
    assign FlushD = ctl.flush_d;
    assign FlushE = ctl.flush_e;
    assign FlushW = ctl.flush_w;
    assign Fault  = (state_q == FAULT);

`ifdef HAZARD_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    // Free-running counters; wrap naturally on overflow.
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_WIDTH'(ctl.stall_d);
        flush_cnt_d = flush_cnt_q + CNT_WIDTH'(ctl.flush_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCount = stall_cnt_q;
    assign FlushCount = flush_cnt_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
